// File: rtl/vm_param.sv
// Parametrised vending-machine controller: accumulates coin credit, vends at PRICE,
// and returns change or a cancel refund as a stream of CHG_UNIT coins.
module vm_param #(
    parameter int unsigned CREDIT_W  = 8,
    parameter int unsigned PRICE     = 15,
    parameter int unsigned COIN0_VAL = 5,
    parameter int unsigned COIN1_VAL = 10,
    parameter int unsigned COIN2_VAL = 25,
    parameter int unsigned CHG_UNIT  = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_sel,
    input  logic                cancel,
    input  logic                product_ready,
    output logic                vend,
    output logic                coin_reject,
    output logic                chg_valid,
    input  logic                chg_ready,
    output logic                chg_last,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int unsigned SUM_W = CREDIT_W + 1;
    localparam logic [SUM_W-1:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

    if (CHG_UNIT == 0 || PRICE == 0 || COIN0_VAL == 0 || COIN1_VAL == 0 || COIN2_VAL == 0 ||
        (PRICE % CHG_UNIT) != 0 || (COIN0_VAL % CHG_UNIT) != 0 ||
        (COIN1_VAL % CHG_UNIT) != 0 || (COIN2_VAL % CHG_UNIT) != 0) begin : g_param_err
        $error("vm_param: PRICE and coin values must be nonzero multiples of CHG_UNIT");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        REFUND  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CREDIT_W-1:0] credit_d;
    logic               vend_d;
    logic               reject_d;
    logic [SUM_W-1:0]   coin_val;
    logic               coin_ok;
    logic [SUM_W-1:0]   sum;

    // Next state, next credit and pulse outputs
    always_comb begin
        state_d  = state_q;
        credit_d = credit;
        vend_d   = 1'b0;
        reject_d = 1'b0;
        coin_ok  = 1'b1;
        coin_val = '0;
        case (coin_sel)
            2'b00:   coin_val = SUM_W'(COIN0_VAL);
            2'b01:   coin_val = SUM_W'(COIN1_VAL);
            2'b10:   coin_val = SUM_W'(COIN2_VAL);
            default: coin_ok  = 1'b0;
        endcase
        sum = {1'b0, credit} + coin_val;

        case (state_q)
            IDLE, COLLECT: begin
                if (cancel && state_q == COLLECT) begin
                    state_d  = REFUND;
                    reject_d = coin_valid;
                end else if (coin_valid) begin
                    // A coin offered alongside an ignored cancel is still refused
                    if (!coin_ok || cancel || sum > CREDIT_MAX) begin
                        reject_d = 1'b1;
                    end else if (sum >= SUM_W'(PRICE)) begin
                        credit_d = CREDIT_W'(sum - SUM_W'(PRICE));
                        state_d  = VEND;
                    end else begin
                        credit_d = CREDIT_W'(sum);
                        state_d  = COLLECT;
                    end
                end
            end
            VEND: begin
                reject_d = coin_valid;
                if (product_ready) begin
                    vend_d  = 1'b1;
                    state_d = (credit != '0) ? REFUND : IDLE;
                end
            end
            REFUND: begin
                reject_d = coin_valid;
                if (chg_ready) begin
                    if (credit == CREDIT_W'(CHG_UNIT)) begin
                        credit_d = '0;
                        state_d  = IDLE;
                    end else begin
                        credit_d = credit - CREDIT_W'(CHG_UNIT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, credit and registered outputs; status flags track the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            credit      <= '0;
            vend        <= 1'b0;
            coin_reject <= 1'b0;
            chg_valid   <= 1'b0;
            chg_last    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit      <= credit_d;
            vend        <= vend_d;
            coin_reject <= reject_d;
            chg_valid   <= (state_d == REFUND);
            chg_last    <= (state_d == REFUND) && (credit_d == CREDIT_W'(CHG_UNIT));
            busy        <= (state_d == VEND) || (state_d == REFUND);
        end
    end

endmodule

// File: tb/tb_vm_param.sv
// Scoreboard bench for vm_param: default instance plus a narrow-credit instance.
module tb_vm_param;

    localparam logic [1:0] K_REJ  = 2'd0;
    localparam logic [1:0] K_VEND = 2'd1;
    localparam logic [1:0] K_CHG  = 2'd2;

    typedef struct {
        logic [1:0] kind;
        logic       last;
        logic [7:0] credit;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_sel = 2'b00;
    logic       cancel = 1'b0;
    logic       product_ready = 1'b1;
    logic       chg_ready = 1'b1;
    logic       vend, coin_reject, chg_valid, chg_last, busy;
    logic [7:0] credit;

    logic       s_coin_valid = 1'b0;
    logic [1:0] s_coin_sel = 2'b00;
    logic       s_vend, s_coin_reject, s_chg_valid, s_chg_last, s_busy;
    logic [4:0] s_credit;

    int n_checks = 0;
    int n_pass   = 0;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    vm_param u_dut (
        .clk(clk), .reset_n(reset_n), .coin_valid(coin_valid), .coin_sel(coin_sel),
        .cancel(cancel), .product_ready(product_ready), .vend(vend),
        .coin_reject(coin_reject), .chg_valid(chg_valid), .chg_ready(chg_ready),
        .chg_last(chg_last), .credit(credit), .busy(busy)
    );

    vm_param #(.CREDIT_W(5), .PRICE(30)) u_small (
        .clk(clk), .reset_n(reset_n), .coin_valid(s_coin_valid), .coin_sel(s_coin_sel),
        .cancel(1'b0), .product_ready(1'b1), .vend(s_vend),
        .coin_reject(s_coin_reject), .chg_valid(s_chg_valid), .chg_ready(1'b1),
        .chg_last(s_chg_last), .credit(s_credit), .busy(s_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    endtask

    task automatic push(input logic [1:0] kind, input logic last, input logic [7:0] cr);
        ev_t e;
        e.kind = kind; e.last = last; e.credit = cr;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [1:0] kind, input logic last, input logic [7:0] cr);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", int'(kind), 99);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", int'(kind), int'(e.kind));
            if (e.kind != K_REJ) chk("ev_credit", int'(cr), int'(e.credit));
            if (e.kind == K_CHG) chk("ev_last", int'(last), int'(e.last));
        end
    endtask

    // Monitor: every DUT output event is matched against the expected queue
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (coin_reject) pop_cmp(K_REJ, 1'b0, credit);
                if (vend) pop_cmp(K_VEND, 1'b0, credit);
                if (chg_valid && chg_ready) pop_cmp(K_CHG, chg_last, credit);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] sel);
        coin_valid = 1'b1;
        coin_sel   = sel;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic s_coin(input logic [1:0] sel);
        s_coin_valid = 1'b1;
        s_coin_sel   = sel;
        tick();
        s_coin_valid = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("queue_drain", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_credit", int'(credit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_chg_valid", int'(chg_valid), 0);
        chk("rst_vend", int'(vend), 0);
        chk("rst_reject", int'(coin_reject), 0);
        reset_n = 1'b1;
        tick();

        // 1) three 5-unit coins, exact price
        coin(2'b00); chk("t1_credit5", int'(credit), 5);
        coin(2'b00); chk("t1_credit10", int'(credit), 10);
        push(K_VEND, 1'b0, 8'd0);
        coin(2'b00); chk("t1_credit0", int'(credit), 0); chk("t1_busy", int'(busy), 1);
        wait_empty(6);
        tick();
        chk("t1_idle_busy", int'(busy), 0);
        chk("t1_idle_chg", int'(chg_valid), 0);

        // 2) one 25 coin, 10 change
        push(K_VEND, 1'b0, 8'd10);
        push(K_CHG, 1'b0, 8'd10);
        push(K_CHG, 1'b1, 8'd5);
        coin(2'b10); chk("t2_credit", int'(credit), 10);
        wait_empty(10);
        chk("t2_end_credit", int'(credit), 0);
        chk("t2_end_busy", int'(busy), 0);

        // 3) cancel refund, then cancel colliding with a coin
        coin(2'b01); chk("t3_credit", int'(credit), 10);
        push(K_CHG, 1'b0, 8'd10);
        push(K_CHG, 1'b1, 8'd5);
        cancel = 1'b1; tick(); cancel = 1'b0;
        wait_empty(10);
        chk("t3_credit0", int'(credit), 0);
        coin(2'b01);
        push(K_REJ, 1'b0, 8'd0);
        push(K_CHG, 1'b0, 8'd10);
        push(K_CHG, 1'b1, 8'd5);
        cancel = 1'b1; coin_valid = 1'b1; coin_sel = 2'b00;
        tick();
        cancel = 1'b0; coin_valid = 1'b0;
        wait_empty(10);
        chk("t3b_credit0", int'(credit), 0);

        // 4) invalid code, then coin while waiting in VEND
        push(K_REJ, 1'b0, 8'd0);
        coin(2'b11); chk("t4_credit0", int'(credit), 0); chk("t4_busy0", int'(busy), 0);
        wait_empty(4);
        product_ready = 1'b0;
        coin(2'b10); chk("t4_vend_credit", int'(credit), 10);
        push(K_REJ, 1'b0, 8'd0);
        coin(2'b00); chk("t4_held_credit", int'(credit), 10); chk("t4_held_busy", int'(busy), 1);
        tick();
        chk("t4_no_vend", int'(vend), 0);
        push(K_VEND, 1'b0, 8'd10);
        push(K_CHG, 1'b0, 8'd10);
        push(K_CHG, 1'b1, 8'd5);
        product_ready = 1'b1;
        wait_empty(10);
        chk("t4_end_credit", int'(credit), 0);

        // 5) stalled refund, then reset mid-refund
        chg_ready = 1'b0;
        coin(2'b01);
        cancel = 1'b1; tick(); cancel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_hold_valid", int'(chg_valid), 1);
            chk("t5_hold_credit", int'(credit), 10);
            chk("t5_hold_last", int'(chg_last), 0);
            tick();
        end
        reset_n = 1'b0;
        #1;
        chk("t5_rst_credit", int'(credit), 0);
        chk("t5_rst_chg", int'(chg_valid), 0);
        chk("t5_rst_busy", int'(busy), 0);
        tick();
        reset_n = 1'b1;
        chg_ready = 1'b1;
        tick();
        chk("t5_after_chg", int'(chg_valid), 0);
        chk("t5_queue", exp_q.size(), 0);

        // 6) narrow accumulator overflow rejection
        s_coin(2'b10); chk("t6_credit25", int'(s_credit), 25);
        s_coin(2'b10); chk("t6_reject", int'(s_coin_reject), 1); chk("t6_held", int'(s_credit), 25);
        s_coin(2'b00); chk("t6_reject_clr", int'(s_coin_reject), 0);
        chk("t6_credit0", int'(s_credit), 0); chk("t6_busy", int'(s_busy), 1);
        tick();
        chk("t6_vend", int'(s_vend), 1); chk("t6_idle", int'(s_busy), 0);
        chk("t6_nochg", int'(s_chg_valid), 0);
        tick();
        chk("t6_vend_clr", int'(s_vend), 0);

        tick();
        chk("final_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
